// File: rtl/clock_reset_seq.sv
// Clock/reset manager: qualifies PLL lock, releases per-channel resets in order,
// and generates per-channel clock-enable strobes from fixed divisors.

module clock_reset_seq_ce #(
    parameter int               DIV_W = 8,
    parameter logic [DIV_W-1:0] DIV   = '0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rst_q,
    input  logic rst_nxt,
    output logic ce
);
    localparam logic [DIV_W-1:0] LAST = DIV - DIV_W'(1);

    logic [DIV_W-1:0] cnt;

    // rst_nxt lets ce drop on the same edge the channel re-enters reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else if (DIV <= DIV_W'(1)) begin
            cnt <= '0;
            ce  <= ~rst_nxt;
        end else if (rst_q || rst_nxt) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            ce  <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            ce  <= 1'b0;
        end
    end
endmodule

module clock_reset_seq #(
    parameter int                    N_CH        = 3,
    parameter int                    LOCK_STABLE = 1024,
    parameter int                    STAGE_DLY   = 16,
    parameter int                    DIV_W       = 8,
    parameter logic [N_CH*DIV_W-1:0] CE_DIV      = {8'd3, 8'd2, 8'd1}
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pll_locked,
    input  logic            soft_rst_req,
    output logic [N_CH-1:0] rst_out,
    output logic [N_CH-1:0] ce,
    output logic            ready,
    output logic [7:0]      lock_loss_cnt
);
    localparam int MAXC  = (LOCK_STABLE > STAGE_DLY) ? LOCK_STABLE : STAGE_DLY;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] DLY_LAST    = CNT_W'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [N_CH-1:0]  rst_d;
    logic             ready_d;
    logic [7:0]       llc_d;
    logic             sync1, locked_s;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1         <= 1'b0;
            locked_s      <= 1'b0;
            state         <= WAIT_LOCK;
            cnt           <= '0;
            idx           <= '0;
            rst_out       <= '1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            sync1         <= pll_locked;
            locked_s      <= sync1;
            state         <= state_d;
            cnt           <= cnt_d;
            idx           <= idx_d;
            rst_out       <= rst_d;
            ready         <= ready_d;
            lock_loss_cnt <= llc_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        rst_d   = rst_out;
        ready_d = ready;
        llc_d   = lock_loss_cnt;
        // lock loss pre-empts everything, including a concurrent soft request
        if (state != WAIT_LOCK && !locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            if (lock_loss_cnt != 8'hFF) llc_d = lock_loss_cnt + 1'b1;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end
                end
                STABLE: begin
                    if (cnt == STABLE_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == DLY_LAST) begin
                        rst_d[idx] = 1'b0;
                        cnt_d      = '0;
                        idx_d      = idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (soft_rst_req) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                        rst_d   = '1;
                        ready_d = 1'b0;
                    end
                end
                default: state_d = WAIT_LOCK;
            endcase
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ce
        clock_reset_seq_ce #(
            .DIV_W (DIV_W),
            .DIV   (CE_DIV[i*DIV_W +: DIV_W])
        ) u_ce (
            .clk     (clk),
            .reset_n (reset_n),
            .rst_q   (rst_out[i]),
            .rst_nxt (rst_d[i]),
            .ce      (ce[i])
        );
    end
endmodule

// File: tb/tb_clock_reset_seq.sv
// Directed bench for clock_reset_seq: bring-up, lock loss, soft re-sequence,
// counter saturation and reset mid-sequence.

module tb_clock_reset_seq;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic [2:0] rst_out;
    logic [2:0] ce;
    logic       ready;
    logic [7:0] lock_loss_cnt;

    int total = 0;
    int bad   = 0;

    clock_reset_seq #(
        .N_CH        (3),
        .LOCK_STABLE (8),
        .STAGE_DLY   (4),
        .DIV_W       (8),
        .CE_DIV      (24'h03_02_01)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .soft_rst_req  (soft_rst_req),
        .rst_out       (rst_out),
        .ce            (ce),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {ready, ce, rst_out} k edges after the edge that enters RELEASE
    function automatic logic [6:0] exp_vec(input int k);
        logic [2:0] r, c;
        logic       rd;
        r[0] = (k < 4);
        r[1] = (k < 8);
        r[2] = (k < 12);
        rd   = (k >= 12);
        c[0] = (k >= 4);
        c[1] = (k >= 10) && (((k - 10) % 2) == 0);
        c[2] = (k >= 15) && (((k - 15) % 3) == 0);
        return {rd, c, r};
    endfunction

    task automatic test_reset();
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        repeat (5) step();
        total++;
        if ({ready, ce, rst_out} !== 7'b0_000_111) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=%b", {ready, ce, rst_out}, 7'b0_000_111);
        end
        total++;
        if (lock_loss_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_llc got=%0d exp=0", lock_loss_cnt);
        end
    endtask

    task automatic test_bringup();
        reset_n = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            step();
            total++;
            if ({ready, ce, rst_out} !== exp_vec(e - 11)) begin
                bad++;
                $display("FAIL bringup e=%0d got=%b exp=%b", e, {ready, ce, rst_out}, exp_vec(e - 11));
            end
        end
        total++;
        if (lock_loss_cnt !== 8'd0) begin
            bad++;
            $display("FAIL bringup_llc got=%0d exp=0", lock_loss_cnt);
        end
    endtask

    task automatic test_lock_blip();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            step();
            total++;
            if ({ready, ce, rst_out} !== exp_vec(e - 17)) begin
                bad++;
                $display("FAIL blip e=%0d got=%b exp=%b", e, {ready, ce, rst_out}, exp_vec(e - 17));
            end
            total++;
            if (lock_loss_cnt !== ((e >= 8) ? 8'd1 : 8'd0)) begin
                bad++;
                $display("FAIL blip_llc e=%0d got=%0d exp=%0d", e, lock_loss_cnt, (e >= 8) ? 1 : 0);
            end
            if (e == 5) pll_locked = 1'b0;
            if (e == 6) pll_locked = 1'b1;
        end
    endtask

    task automatic test_run_loss();
        pll_locked = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            step();
            total++;
            if ({ready, rst_out} !== 4'b1_000) begin
                bad++;
                $display("FAIL runloss_hold e=%0d got=%b exp=1000", e, {ready, rst_out});
            end
        end
        step();
        total++;
        if ({ready, ce, rst_out} !== 7'b0_000_111) begin
            bad++;
            $display("FAIL runloss_reset got=%b exp=%b", {ready, ce, rst_out}, 7'b0_000_111);
        end
        total++;
        if (lock_loss_cnt !== 8'd2) begin
            bad++;
            $display("FAIL runloss_llc got=%0d exp=2", lock_loss_cnt);
        end
        pll_locked = 1'b1;
        for (int m = 1; m <= 24; m++) begin
            step();
            total++;
            if ({ready, ce, rst_out} !== exp_vec(m - 11)) begin
                bad++;
                $display("FAIL relock m=%0d got=%b exp=%b", m, {ready, ce, rst_out}, exp_vec(m - 11));
            end
        end
    endtask

    task automatic test_soft();
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        for (int j = 0; j <= 14; j++) begin
            if (j > 0) step();
            total++;
            if ({ready, ce, rst_out} !== exp_vec(j)) begin
                bad++;
                $display("FAIL soft j=%0d got=%b exp=%b", j, {ready, ce, rst_out}, exp_vec(j));
            end
        end
        total++;
        if (lock_loss_cnt !== 8'd2) begin
            bad++;
            $display("FAIL soft_llc got=%0d exp=2", lock_loss_cnt);
        end
        // request while in STABLE must not shorten the qualification window
        pll_locked = 1'b0;
        repeat (3) step();
        pll_locked = 1'b1;
        repeat (4) step();
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        for (int m = 6; m <= 24; m++) begin
            step();
            total++;
            if ({ready, ce, rst_out} !== exp_vec(m - 11)) begin
                bad++;
                $display("FAIL soft_stable m=%0d got=%b exp=%b", m, {ready, ce, rst_out}, exp_vec(m - 11));
            end
        end
        total++;
        if (lock_loss_cnt !== 8'd3) begin
            bad++;
            $display("FAIL soft_stable_llc got=%0d exp=3", lock_loss_cnt);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            repeat (3) step();
            pll_locked = 1'b1;
            repeat (3) step();
            if (i == 249) begin
                total++;
                if (lock_loss_cnt !== 8'd253) begin
                    bad++;
                    $display("FAIL sat_mid got=%0d exp=253", lock_loss_cnt);
                end
            end
        end
        total++;
        if (lock_loss_cnt !== 8'd255) begin
            bad++;
            $display("FAIL sat_end got=%0d exp=255", lock_loss_cnt);
        end
        // now in STABLE; run into RELEASE and past the first release
        repeat (13) step();
        total++;
        if (rst_out !== 3'b110) begin
            bad++;
            $display("FAIL midrelease got=%b exp=110", rst_out);
        end
        reset_n = 1'b0;
        step();
        total++;
        if ({ready, ce, rst_out, lock_loss_cnt} !== {7'b0_000_111, 8'd0}) begin
            bad++;
            $display("FAIL reset_midseq got=%b exp=%b", {ready, ce, rst_out, lock_loss_cnt}, {7'b0_000_111, 8'd0});
        end
        reset_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            total++;
            if ({ready, ce, rst_out} !== exp_vec(e - 11)) begin
                bad++;
                $display("FAIL after_reset e=%0d got=%b exp=%b", e, {ready, ce, rst_out}, exp_vec(e - 11));
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_lock_blip();
        test_run_loss();
        test_soft();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
